pll_reset_sequencer: RTL

// - Controls the four-output system PLL (50 MHz refclk in; 100/150/300/450 MHz out) from the refclk domain.
// - Pulses the PLL reset, waits for lock with a timeout and retry limit, then debounces lock.
// - Releases per-clock-domain resets in a fixed staggered order.
// - In RUN, monitors for loss of lock and re-runs the full sequence.
// - Sits between board reset and every logic block clocked by PLL outputs (Nios system, frequency counters, display).

---
 rtl/pll_seq_pkg.sv | 37 +++
 rtl/pll_reset_sequencer_sync_2ff.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the encoding is visible on state_o for debug/CSR reads.
    typedef enum logic [2:0] {
        S_ASSERT  = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } pll_state_e;

    localparam int LOL_CNT_W = 8;

    // Largest of four integers, used to size the shared timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Saturating increment for the loss-of-lock counter.
    function automatic logic [LOL_CNT_W-1:0] sat_inc(input logic [LOL_CNT_W-1:0] v);
        logic [LOL_CNT_W-1:0] r;
        if (v == {LOL_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(LOL_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values of the synchronizer chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops; cleared to "not locked" on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for and debounces lock,
// releases the per-domain resets in staggered order and re-runs the whole
// sequence whenever lock is lost after release.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 8,
    parameter int NUM_DOMAINS   = 4,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_restart,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   ready,
    output logic                   fail,
    output logic [LOL_CNT_W-1:0]   lol_count,
    output logic [2:0]             state_o
);

    localparam int TW = $clog2(max4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                    RELEASE_GAP * NUM_DOMAINS) + 1);
    localparam int AW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    // Terminal timer values: the last cycle spent in each timed state.
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST    = TW'((NUM_DOMAINS - 1) * RELEASE_GAP);
    localparam logic [AW-1:0] ATT_MAX     = AW'(MAX_RETRIES);

    logic                   lk_s;

    pll_state_e             state_d,    state_q;
    logic [TW-1:0]          timer_d,    timer_q;
    logic [AW-1:0]          attempts_d, attempts_q;
    logic [LOL_CNT_W-1:0]   lol_d,      lol_q;
    logic                   pll_rst_d,  pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_d,   domain_q;
    logic                   ready_d,    ready_q;
    logic                   fail_d,     fail_q;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Next-state, timer, counters and the registered-output values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TW'(1);
        attempts_d = attempts_q;
        lol_d      = lol_q;
        domain_d   = {NUM_DOMAINS{1'b0}};

        if (sw_restart) begin
            state_d    = S_ASSERT;
            timer_d    = {TW{1'b0}};
            attempts_d = {AW{1'b0}};
        end else begin
            case (state_q)
                S_ASSERT: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT;
                        timer_d = {TW{1'b0}};
                    end else begin
                        state_d = S_ASSERT;
                    end
                end
                S_WAIT: begin
                    if (lk_s) begin
                        state_d = S_STABLE;
                        timer_d = {TW{1'b0}};
                    end else if (timer_q == LOCK_LAST) begin
                        timer_d = {TW{1'b0}};
                        if (attempts_q == ATT_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d    = S_ASSERT;
                            attempts_d = attempts_q + AW'(1);
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_STABLE: begin
                    // A single low sample restarts the lock wait but is not a new attempt.
                    if (!lk_s) begin
                        state_d = S_WAIT;
                        timer_d = {TW{1'b0}};
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RELEASE;
                        timer_d = {TW{1'b0}};
                    end else begin
                        state_d = S_STABLE;
                    end
                end
                S_RELEASE, S_RUN: begin
                    // Loss of lock once any domain may be out of reset.
                    if (!lk_s) begin
                        state_d    = S_ASSERT;
                        timer_d    = {TW{1'b0}};
                        attempts_d = {AW{1'b0}};
                        lol_d      = sat_inc(lol_q);
                    end else if (state_q == S_RUN) begin
                        timer_d = timer_q;
                    end else if (timer_q == REL_LAST) begin
                        state_d = S_RUN;
                        timer_d = {TW{1'b0}};
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                    timer_d = timer_q;
                end
                default: begin
                    state_d    = S_ASSERT;
                    timer_d    = {TW{1'b0}};
                    attempts_d = {AW{1'b0}};
                end
            endcase
        end

        // Outputs follow the next state so they are registered yet aligned with state_q.
        pll_rst_d = (state_d == S_ASSERT) || (state_d == S_FAIL);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);

        if (state_d == S_RUN) begin
            domain_d = {NUM_DOMAINS{1'b1}};
        end else if (state_d == S_RELEASE) begin
            // Bit i is released once the release timer reaches i*RELEASE_GAP.
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                domain_d[i] = (timer_d >= TW'(i * RELEASE_GAP));
            end
        end else begin
            domain_d = {NUM_DOMAINS{1'b0}};
        end
    end

    // State, timer, counters and output registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ASSERT;
            timer_q    <= {TW{1'b0}};
            attempts_q <= {AW{1'b0}};
            lol_q      <= {LOL_CNT_W{1'b0}};
            pll_rst_q  <= 1'b1;
            domain_q   <= {NUM_DOMAINS{1'b0}};
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            attempts_q <= attempts_d;
            lol_q      <= lol_d;
            pll_rst_q  <= pll_rst_d;
            domain_q   <= domain_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign domain_rst_n = domain_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign lol_count    = lol_q;
    assign state_o      = state_q;

endmodule
